// File: rtl/cnt_obi_pkg.sv
// Shared OBI payload types, FSM state encoding and sizing helpers for the burst initiator.
package cnt_obi_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned BeW   = DataW / 8;
  localparam int unsigned LenW  = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } state_e;

  typedef struct packed {
    logic             req;
    logic             we;
    logic [BeW-1:0]   be;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic             gnt;
    logic             rvalid;
    logic [DataW-1:0] rdata;
  } obi_resp_t;

  // Beat index spans 0..max_len-1
  function automatic int unsigned beat_width(input int unsigned max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

endpackage

// File: rtl/obi_burst_initiator.sv
// OBI manager issuing incrementing single-outstanding bursts of up to MaxLen beats,
// with generated write data and per-beat read responses.
module obi_burst_initiator
  import cnt_obi_pkg::*;
#(
  parameter int unsigned MaxLen = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [AddrW-1:0] cmd_addr_i,
  input  logic [DataW-1:0] cmd_wdata_i,
  input  logic [LenW-1:0]  cmd_len_i,
  output logic             rsp_valid_o,
  output logic [DataW-1:0] rsp_rdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [BeW-1:0]   bus_be_o,
  output logic [AddrW-1:0] bus_addr_o,
  output logic [DataW-1:0] bus_wdata_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [DataW-1:0] bus_rdata_i
);

  localparam int unsigned BeatW = beat_width(MaxLen);

  state_e           state_q, state_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [LenW-1:0]  len_q, len_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  obi_req_t         bus_q, bus_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DataW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic             done_q, done_d;

  obi_resp_t        bus_rsp;
  logic [LenW-1:0]  len_eff;
  logic             more_beats;

  assign bus_rsp    = '{gnt: bus_gnt_i, rvalid: bus_rvalid_i, rdata: bus_rdata_i};
  assign len_eff    = (cmd_len_i > LenW'(MaxLen)) ? LenW'(MaxLen) : cmd_len_i;
  assign more_beats = (LenW'(beat_q) + LenW'(1)) < len_q;

  // Next-state and next-output logic; bus payload is derived from the next state
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    len_d       = len_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    done_d      = 1'b0;
    bus_d       = '0;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (len_eff != '0) begin
            state_d = REQ;
            beat_d  = '0;
            len_d   = len_eff;
            we_d    = cmd_we_i;
            addr_d  = cmd_addr_i & ~32'h3;
            wdata_d = cmd_wdata_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (bus_rsp.gnt) state_d = WAIT_R;
      end
      WAIT_R: begin
        if (bus_rsp.rvalid) begin
          if (!we_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus_rsp.rdata;
          end
          if (more_beats) begin
            state_d = REQ;
            beat_d  = beat_q + BeatW'(1);
            addr_d  = addr_q + 32'd4;
            wdata_d = wdata_q + 32'd1;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == REQ) begin
      bus_d.req   = 1'b1;
      bus_d.we    = we_d;
      bus_d.be    = 4'hF;
      bus_d.addr  = addr_d;
      bus_d.wdata = wdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      len_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bus_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bus_q       <= bus_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign bus_req_o   = bus_q.req;
  assign bus_we_o    = bus_q.we;
  assign bus_be_o    = bus_q.be;
  assign bus_addr_o  = bus_q.addr;
  assign bus_wdata_o = bus_q.wdata;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign done_o      = done_q;

`ifndef SYNTHESIS
  // A response is only legal while a granted transaction is outstanding
  rvalid_in_wait_r: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus_rvalid_i |-> (state_q == WAIT_R));
`endif

endmodule

// File: tb/tb_obi_burst_initiator.sv
// Randomized bench for obi_burst_initiator: a bus slave with memory and random
// gnt/rvalid delays, and a command-level model of addresses, data and timing.
module tb_obi_burst_initiator;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic [4:0]  cmd_len_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        busy_o;
  logic        done_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;

  obi_burst_initiator #(.MaxLen(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_len_i(cmd_len_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .busy_o(busy_o), .done_o(done_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave-owned state
  txn_t        obs_q[$];
  logic [31:0] slave_mem[logic [31:0]];
  int          grants    = 0;
  int          cost_sum  = 0;
  // Main-owned state
  logic [31:0] model_mem[logic [31:0]];
  int          obs_rd    = 0;
  int          cost_base = 0;
  int unsigned gd_lo = 0, gd_hi = 0, rd_lo = 0, rd_hi = 0;
  int          stall_grant = -1;
  bit          late_rv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  // Bus slave: decides gnt/rvalid on the falling edge, checks bus hygiene
  initial begin : bus_slave
    bit          pend = 1'b0;
    bit          stalled = 1'b0;
    int          gnt_wait = -1;
    int          gd_cur = 0;
    int          rv_wait = 0;
    logic [31:0] pend_rdata = '0;
    logic [31:0] snap_addr = '0, snap_wdata = '0;
    logic        snap_we = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
      if (!rst_ni) begin
        pend = 1'b0; gnt_wait = -1; stalled = 1'b0;
        if (late_rv) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = 32'hDEAD_BEEF;
        end
      end else begin
        if (stalled) begin
          check("stall_addr", bus_addr_o, snap_addr);
          check("stall_wdata", bus_wdata_o, snap_wdata);
          check("stall_ctrl", 32'({bus_req_o, bus_we_o, bus_be_o}), 32'({1'b1, snap_we, 4'hF}));
          stalled = 1'b0;
        end
        if (!bus_req_o) check("idle_zero", 32'(bus_be_o) | bus_addr_o | bus_wdata_o, 32'd0);
        else check("req_be", 32'(bus_be_o), 32'hF);
        check("busy_vs_ready", 32'(busy_o), 32'(!cmd_ready_o));
        if (pend) begin
          check("one_outstanding", 32'(bus_req_o), 32'd0);
          if (rv_wait == 0) begin
            bus_rvalid_i = 1'b1; bus_rdata_i = pend_rdata; pend = 1'b0;
          end else begin
            rv_wait--;
          end
        end else if (bus_req_o) begin
          if (gnt_wait < 0) begin
            gnt_wait = int'($urandom_range(gd_hi, gd_lo));
            gd_cur = gnt_wait;
          end
          if (gnt_wait == 0) begin
            bus_gnt_i = 1'b1; gnt_wait = -1;
            rv_wait = (grants == stall_grant) ? 1000000 : int'($urandom_range(rd_hi, rd_lo));
            cost_sum += gd_cur + rv_wait + 2;
            grants++;
            obs_q.push_back('{we: bus_we_o, addr: bus_addr_o, wdata: bus_wdata_o});
            if (bus_we_o) slave_mem[bus_addr_o] = bus_wdata_o;
            else pend_rdata = slave_mem.exists(bus_addr_o) ? slave_mem[bus_addr_o] : init_word(bus_addr_o);
            pend = 1'b1;
          end else begin
            gnt_wait--;
            stalled = 1'b1; snap_addr = bus_addr_o; snap_wdata = bus_wdata_o; snap_we = bus_we_o;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  // Present a command; on return it is accepted at the next rising edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] seed,
                       input logic [4:0] len);
    int guard = 0;
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = seed; cmd_len_i = len;
    while (!cmd_ready_o && guard < 400) begin
      tick(); guard++;
    end
    check("cmd_accept", 32'(cmd_ready_o), 32'd1);
    cost_base = cost_sum;
  endtask

  // Follow one command to done_o and compare everything against the model
  task automatic wait_done(input logic we, input logic [31:0] addr, input logic [31:0] seed,
                           input logic [4:0] len, output int n);
    logic [31:0] rsp[$];
    bit          seen = 1'b0;
    int          exp_n;
    logic [31:0] ea;
    txn_t        t;
    n = 0;
    while (n < 600) begin
      tick(); n++;
      if (n == 1) cmd_valid_i = 1'b0;
      if (rsp_valid_o) rsp.push_back(rsp_rdata_o);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    exp_n = (len == 5'd0) ? 1 : 1 + (cost_sum - cost_base);
    check("done_latency", 32'(n), 32'(exp_n));
    check("done_rsp_align", 32'(rsp_valid_o), 32'(!we && len != 5'd0));
    check("ready_at_done", 32'({busy_o, cmd_ready_o}), 32'h1);
    check("rsp_count", 32'(rsp.size()), we ? 32'd0 : 32'(len));
    check("txn_count", 32'(obs_q.size() - obs_rd), 32'(len));
    for (int k = 0; k < int'(len) && obs_rd < obs_q.size(); k++) begin
      t  = obs_q[obs_rd];
      obs_rd++;
      ea = (addr & 32'hFFFF_FFFC) + 32'(k) * 32'd4;
      check("beat_addr", t.addr, ea);
      check("beat_we", 32'(t.we), 32'(we));
      if (we) begin
        check("beat_wdata", t.wdata, seed + 32'(k));
        model_mem[ea] = seed + 32'(k);
      end else if (k < rsp.size()) begin
        check("rsp_rdata", rsp[k], model_read(ea));
      end
    end
    obs_rd = obs_q.size();
  endtask

  task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] seed,
                     input logic [4:0] len, output int n);
    issue(we, addr, seed, len);
    wait_done(we, addr, seed, len, n);
  endtask

  initial begin : main
    int n;
    int guard;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_we_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0; cmd_len_i = '0;
    repeat (3) tick();
    check("rst_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_flags", 32'({busy_o, done_o, rsp_valid_o, bus_req_o, bus_we_o}), 32'd0);
    check("rst_bus", 32'(bus_be_o) | bus_addr_o | bus_wdata_o | rsp_rdata_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Zero-wait write burst: 2 cycles per beat
    run(1'b1, 32'h0000_1000, 32'h0000_00A0, 5'd4, n);
    check("wr4_bus_cycles", 32'(n - 1), 32'd8);

    // Read with unaligned base and 3-cycle grant stall per beat
    gd_lo = 3; gd_hi = 3;
    run(1'b0, 32'h0000_2002, 32'h0, 5'd3, n);
    check("rd3_cycles", 32'(n - 1), 32'd15);
    gd_lo = 0; gd_hi = 0;

    // Empty command
    run(1'b1, 32'h0000_3000, 32'h1, 5'd0, n);
    check("len0_latency", 32'(n), 32'd1);

    // Address wrap, then read back across the wrap
    run(1'b1, 32'hFFFF_FFFC, 32'h0000_0055, 5'd2, n);
    run(1'b0, 32'hFFFF_FFFD, 32'h0, 5'd2, n);

    // Reset while waiting for the response of beat 2 of 4
    stall_grant = grants + 1;
    obs_rd = obs_q.size();
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h0000_3000; cmd_len_i = 5'd4;
    tick();
    cmd_valid_i = 1'b0;
    guard = 0;
    while (grants < stall_grant + 1 && guard < 50) begin
      tick(); guard++;
    end
    tick();
    check("rst_mid_busy", 32'({busy_o, bus_req_o}), 32'h2);
    rst_ni = 1'b0; late_rv = 1'b1;
    tick();
    check("rst_mid_bus", 32'({bus_req_o, done_o, rsp_valid_o, busy_o}), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready_o), 32'd1);
    late_rv = 1'b0;
    tick();
    check("rst_late_rv", 32'({done_o, rsp_valid_o}), 32'd0);
    rst_ni = 1'b1;
    tick();
    check("rst_after", 32'({bus_req_o, done_o, rsp_valid_o, busy_o}), 32'd0);
    check("rst_txns", 32'(obs_q.size() - obs_rd), 32'd2);
    if (obs_q.size() - obs_rd == 2) check("rst_beat2_addr", obs_q[obs_rd + 1].addr, 32'h0000_3004);
    obs_rd = obs_q.size();
    stall_grant = -1;

    // Back-to-back: second command presented in the done_o cycle
    run(1'b1, 32'h0000_5000, 32'hCAFE_0000, 5'd3, n);
    run(1'b0, 32'h0000_5000, 32'h0, 5'd3, n);
    check("b2b_cycles", 32'(n - 1), 32'd6);

    // Randomized commands
    for (int i = 0; i < 40; i++) begin
      logic        we;
      logic [31:0] addr, seed;
      logic [4:0]  len;
      if (n_fail > 40) break;
      gd_lo = 0; gd_hi = $urandom_range(3, 0);
      rd_lo = 0; rd_hi = $urandom_range(3, 0);
      we   = 1'($urandom_range(1, 0));
      seed = $urandom;
      len  = 5'($urandom_range(16, 0));
      if ($urandom_range(7, 0) == 0) addr = 32'hFFFF_FFE0 | 32'($urandom_range(31, 0));
      else addr = 32'h4000_0000 | (32'($urandom_range(31, 0)) << 2) | 32'($urandom_range(3, 0));
      run(we, addr, seed, len, n);
      repeat ($urandom_range(2, 0)) tick();
    end

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obi_burst_initiator.md
OBI_BURST_INITIATOR -- requirements
Module: obi_burst_initiator

Interface
REQ-001 Parameter MaxLen, default 16, maximum beats per command (power of two, 1..16).
REQ-002 clk_i  in  1  single clock; all logic rising-edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 cmd_valid_i  in  1  command request from local controller.
REQ-005 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-006 cmd_we_i  in  1  1 = write burst, 0 = read burst.
REQ-007 cmd_addr_i  in  32  byte base address; bits [1:0] ignored.
REQ-008 cmd_wdata_i  in  32  write seed; beat k writes seed + k.
REQ-009 cmd_len_i  in  5  beat count, 0..MaxLen.
REQ-010 rsp_valid_o  out  1  one-cycle pulse per read beat returned.
REQ-011 rsp_rdata_o  out  32  read data qualified by rsp_valid_o.
REQ-012 busy_o  out  1  high while a command is in progress.
REQ-013 done_o  out  1  one-cycle pulse at command completion.
REQ-014 bus_req_o, bus_we_o  out  1 each  OBI manager request / write enable.
REQ-015 bus_be_o  out  4  byte enables, always 4'hF during a request.
REQ-016 bus_addr_o, bus_wdata_o  out  32 each  OBI address / write data.
REQ-017 bus_gnt_i, bus_rvalid_i  in  1 each  OBI grant / response valid.
REQ-018 bus_rdata_i  in  32  OBI read data.

Function
REQ-019 FSM states: IDLE, REQ, WAIT_R; cmd_ready_o = (state == IDLE); busy_o = (state != IDLE).
REQ-020 IDLE + cmd_valid_i with len > 0: latch cmd, beat counter = 0, go REQ; bus_req_o rises the following cycle (registered).
REQ-021 IDLE + cmd_valid_i with len == 0: accepted, no bus activity, done_o pulses the next cycle, stays IDLE.
REQ-022 REQ: bus_req_o = 1; addr = {base[31:2],2'b00} + 4*k, modulo 2^32 (wrap-around permitted); wdata = seed + k modulo 2^32.
REQ-023 REQ: addr/we/be/wdata held stable until bus_gnt_i; on gnt go WAIT_R, bus_req_o low next cycle.
REQ-024 At most one transaction outstanding; no new request issued before the rvalid of the previous one.
REQ-025 WAIT_R: on bus_rvalid_i, if read, register rsp_rdata_o = bus_rdata_i and pulse rsp_valid_o next cycle; writes ignore bus_rdata_i.
REQ-026 WAIT_R on rvalid: if k+1 < len, increment k, go REQ; else go IDLE and pulse done_o next cycle (coincident with last rsp_valid_o for reads).
REQ-027 bus_rvalid_i seen in IDLE or REQ is ignored (protocol violation, flagged by assertion).
REQ-028 Non-request cycles: bus_req_o = 0, bus_be_o = 0, bus_addr_o/bus_wdata_o = 0.
REQ-029 Back-to-back: cmd accepted in the cycle done_o is high; minimum 2 cycles per beat with zero-wait gnt/rvalid.

Reset
REQ-030 While rst_ni low at a clock edge: state IDLE, all outputs 0 except cmd_ready_o, which follows IDLE (1) after the edge.
REQ-031 Reset mid-burst aborts: bus_req_o low after the reset edge, no done_o, late rvalid ignored.

Structure
REQ-032 obi_req_t / obi_resp_t and the FSM state enum live in the shared cnt_obi_pkg; beat width constant derived from MaxLen.
REQ-033 Single flat module; no sub-module; address/data incrementers inline.

Verification
REQ-034 Write len=4, addr 0x1000, seed 0xA0, gnt/rvalid zero-wait -> writes 0xA0..0xA3 at 0x1000..0x100C, done_o 1 pulse, 8 bus cycles.
REQ-035 Read len=3, addr 0x2002, gnt delayed 3 cycles per beat -> addresses 0x2000/04/08, signals stable while stalled, 3 rsp_valid_o pulses with memory data.
REQ-036 len=0 command -> no bus_req_o, done_o one cycle after acceptance.
REQ-037 Write len=2 at 0xFFFFFFFC -> second beat address 0x00000000.
REQ-038 Reset asserted while in WAIT_R of beat 2/4 -> bus idle next cycle, no done_o, late rvalid produces no rsp_valid_o.
REQ-039 Two commands back-to-back (cmd_valid_i held) -> second accepted in done_o cycle, no gap beyond REQ-029.
